alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width; legal range 4..32.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 Port in_valid  input  1: operands and opcode are valid this cycle.
REQ-005 Port in_ready  output  1: block accepts an operation this cycle.
REQ-006 Port A  input  WIDTH: operand A.
REQ-007 Port B  input  WIDTH: operand B.
REQ-008 Port OP  input  3: opcode; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-009 Port out_valid  output  1: RES and FLAGS hold a completed result.
REQ-010 Port out_ready  input  1: consumer takes the result this cycle.
REQ-011 Port RES  output  WIDTH: registered result.
REQ-012 Port FLAGS  output  4: registered {N, V, C, Z}.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept: in_valid && in_ready at an edge SHALL latch A, B and OP.
REQ-015 Non-MUL ops SHALL go IDLE->DONE at the accepting edge, so out_valid rises 1 cycle after acceptance.
REQ-016 MUL SHALL go IDLE->BUSY, run shift-add over WIDTH cycles, then BUSY->DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-017 DONE SHALL hold RES, FLAGS and out_valid stable until out_valid && out_ready, then go to IDLE.
REQ-018 in_valid in BUSY or DONE SHALL be ignored; no queueing.
REQ-019 ADD/SUB: RES = (A +/- B) mod 2^WIDTH; C = carry out for ADD and borrow (A < B unsigned) for SUB.
REQ-020 V SHALL be signed two's-complement overflow for ADD/SUB and 0 for all other ops.
REQ-021 AND/OR/XOR: bitwise result; C = 0.
REQ-022 SHL/SHR: logical shift of A by B[clog2(WIDTH)-1:0]; C = last bit shifted out, or 0 for shift amount 0.
REQ-023 MUL: RES = low WIDTH bits of unsigned A*B; C = 1 iff the high WIDTH bits are nonzero.
REQ-024 Z = (RES == 0) and N = RES[WIDTH-1] for every op.
REQ-025 Changes on A, B or OP after acceptance SHALL not affect the operation in flight.

Reset
REQ-026 rst_n low SHALL force state IDLE, out_valid 0, RES 0 and FLAGS 0 immediately, regardless of clk.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 at the first edge.
REQ-028 Reset during BUSY or DONE SHALL abort the operation; no out_valid SHALL follow for it.

Configuration
REQ-029 Macro ALU_MUL_EN SHALL compile the MUL datapath and the BUSY state in.
REQ-030 Without ALU_MUL_EN, OP 111 SHALL complete like a single-cycle op with RES = 0 and FLAGS = 4'b0001, and BUSY SHALL be unreachable.

Verification
REQ-031 WIDTH=8, ADD A=0xFF B=0x01 -> one cycle later out_valid=1, RES=0x00, FLAGS: Z=1 C=1 V=0 N=0.
REQ-032 WIDTH=8, SUB A=0x80 B=0x01 -> RES=0x7F, V=1, C=0, N=0.
REQ-033 ALU_MUL_EN, WIDTH=8, MUL A=0x10 B=0x11 -> out_valid 9 cycles after acceptance, RES=0x10, C=1; in_ready=0 throughout.
REQ-034 SHL A=0x81 B=0x01 with out_ready held 0 for 5 cycles -> RES=0x02, C=1 held stable; in_ready rises the cycle after out_ready=1.
REQ-035 rst_n pulsed low mid-MUL -> out_valid=0 and RES=0 immediately; no stale result; next ADD 3+4 -> RES=0x07.
REQ-036 Without ALU_MUL_EN, OP=111 -> 1-cycle latency, RES=0, FLAGS=4'b0001.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered RES/FLAGS = {N, V, C, Z}.
// Single-cycle ops go IDLE->DONE on the accepting edge. The result then
// stays in DONE until the consumer takes it.
// Optional feature macro ALU_MUL_EN: when defined, a WIDTH-cycle shift-add
// MUL and the BUSY state are built in. Without it, MUL completes at once
// with RES = 0 and FLAGS = 4'b0001.
//
// state | meaning
// IDLE  | ready, in_ready = 1
// BUSY  | shift-add multiply in progress (ALU_MUL_EN only)
// DONE  | RES/FLAGS valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RES,
  output logic [3:0]       FLAGS
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             accept;
  logic             go_busy;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext;
  logic [SW-1:0]    sh_amt;

  assign accept = (state_q == IDLE) && in_valid;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  assign go_busy = (OP == OP_MUL);

  // Multiplier registers: load on accept, one shift-add step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Shift-add step; cnt_q is a down-counter, zero means the product is complete
  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept && go_busy) begin
      prod_d   = '0;
      mcand_d  = {{WIDTH{1'b0}}, A};
      mplier_d = B;
      cnt_d    = CW'(WIDTH);
    end else if (state_q == BUSY && cnt_q != '0) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end
`else
  assign go_busy = 1'b0;
`endif

  // Single-cycle ALU on the live inputs, used only at the accepting edge
  always_comb begin
    sh_amt  = B[SW-1:0];
    add_ext = {1'b0, A} + {1'b0, B};
    sub_ext = {1'b0, A} - {1'b0, B};
    shl_ext = {1'b0, A} << sh_amt;
    shr_ext = {A, 1'b0} >> sh_amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OP)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; in_valid outside IDLE is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = go_busy ? BUSY : DONE;
      BUSY: begin
`ifdef ALU_MUL_EN
        if (cnt_q == '0) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Result capture: at accept for single-cycle ops, at end of BUSY for MUL
  always_comb begin
    res_d   = res_q;
    flags_d = flags_q;
    if (accept && !go_busy) begin
      res_d   = alu_res;
      flags_d = {alu_res[WIDTH-1], alu_v, alu_c, alu_res == '0};
    end
`ifdef ALU_MUL_EN
    else if (state_q == BUSY && cnt_q == '0) begin
      res_d   = prod_q[WIDTH-1:0];
      flags_d = {prod_q[WIDTH-1], 1'b0, |prod_q[2*WIDTH-1:WIDTH],
                 prod_q[WIDTH-1:0] == '0};
    end
`endif
  end

  // Result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign RES   = res_q;
  assign FLAGS = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flags;
  } exp_t;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] OP = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] RES;
  logic [3:0] FLAGS;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  vec_t vecs[16];

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
    .RES(RES), .FLAGS(FLAGS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op, scramble inputs after accept, hold the result 'hold' cycles, then take it.
  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                        input int hold);
    int lat;
    int exp_lat;
    logic busy_bad;
    exp_t e;
    exp_lat = (op == 3'b111 && MUL_EN) ? 9 : 1;
    chk({name, "_in_ready_idle"}, in_ready, 1);
    A = a; B = b; OP = op; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back('{er, ef});
    step();
    A = 8'($urandom); B = 8'($urandom); OP = 3'($urandom);
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      A = 8'($urandom); B = 8'($urandom); OP = 3'($urandom);
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_in_ready"}, busy_bad, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_res"}, RES, er);
      chk({name, "_hold_flags"}, FLAGS, ef);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({name, "_res"}, RES, e.res);
      chk({name, "_flags"}, FLAGS, e.flags);
    end
    step();
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, out_valid, 0);
    chk({name, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int quiet_bad;
    // op, A, B, RES, {N,V,C,Z}
    vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[1]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0100};
    vecs[2]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b1100};
    vecs[3]  = '{3'b001, 8'h01, 8'h02, 8'hFF, 4'b1010};
    vecs[4]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[5]  = '{3'b011, 8'h00, 8'h00, 8'h00, 4'b0001};
    vecs[6]  = '{3'b100, 8'hAA, 8'hFF, 8'h55, 4'b0000};
    vecs[7]  = '{3'b101, 8'h81, 8'h01, 8'h02, 4'b0010};
    vecs[8]  = '{3'b110, 8'h81, 8'h01, 8'h40, 4'b0010};
    vecs[9]  = '{3'b101, 8'h81, 8'h08, 8'h81, 4'b1000};
    vecs[10] = '{3'b110, 8'hC0, 8'h07, 8'h01, 4'b0010};
    vecs[11] = '{3'b101, 8'h03, 8'h07, 8'h80, 4'b1010};
    vecs[12] = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b0001};
    vecs[13] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b0111};
`ifdef ALU_MUL_EN
    vecs[14] = '{3'b111, 8'h10, 8'h11, 8'h10, 4'b0010};
    vecs[15] = '{3'b111, 8'h0F, 8'h0F, 8'hE1, 4'b1000};
`else
    vecs[14] = '{3'b111, 8'h10, 8'h11, 8'h00, 4'b0001};
    vecs[15] = '{3'b111, 8'h0F, 8'h0F, 8'h00, 4'b0001};
`endif

    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_res", RES, 0);
    chk("reset_flags", FLAGS, 0);
    #9 rst_n = 1'b1;
    step();
    chk("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].flags, i % 3);
    end

    // Backpressure: result held 5 cycles while in_valid is ignored
    run_op("shl_backpressure", 3'b101, 8'h81, 8'h01, 8'h02, 4'b0010, 5);

    // Reset while in DONE: outputs clear immediately, no result follows
    A = 8'h10; B = 8'h20; OP = 3'b000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("r1_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r1_valid_async", out_valid, 0);
    chk("r1_res_async", RES, 0);
    chk("r1_flags_async", FLAGS, 0);
    chk("r1_in_ready_async", in_ready, 1);
    step();
    #2 rst_n = 1'b1;
    #1;
    chk("r1_in_ready_release", in_ready, 1);
    quiet_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) quiet_bad = 1;
    end
    chk("r1_no_stale", quiet_bad, 0);
    run_op("r1_add_after", 3'b000, 8'h03, 8'h04, 8'h07, 4'b0000, 0);

`ifdef ALU_MUL_EN
    // Reset mid-MUL: RES left at 0x07 must clear, multiply must not complete
    A = 8'h10; B = 8'h11; OP = 3'b111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("r2_busy_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("r2_valid_async", out_valid, 0);
    chk("r2_res_async", RES, 0);
    chk("r2_flags_async", FLAGS, 0);
    step();
    #2 rst_n = 1'b1;
    #1;
    chk("r2_in_ready_release", in_ready, 1);
    quiet_bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) quiet_bad = 1;
    end
    chk("r2_no_stale", quiet_bad, 0);
    run_op("r2_add_after", 3'b000, 8'h03, 8'h04, 8'h07, 4'b0000, 0);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
